gate_tt_sequencer: RTL and testbench

//   Sequencer for one N-input combinational gate under test (e.g. and_gate).
//   On start it drives every input vector 0..2**N_INPUTS-1 onto the gate.

---
 rtl/gate_tt_sequencer_if.sv | 55 +++++
 rtl/gate_tt_sequencer.sv | 177 +++++++++++++++++
 tb/tb_gate_tt_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/gate_tt_sequencer_if.sv
// ---------------------------------------------------------------------------
// gate_tt_sequencer_if
// Purpose : bundles the host-facing and gate-facing signals of the truth-table
//           sequencer into one interface.
// Signals :
//   start        host -> seq   run request (sampled only while idle)
//   expected     host -> seq   expected truth table, bit i for vector i
//   gate_in      seq  -> gate  vector applied to the gate under test
//   gate_out     gate -> seq   gate output
//   busy         seq  -> host  run in progress
//   done         seq  -> host  one-cycle completion pulse
//   truth_table  seq  -> host  captured gate outputs, bit i for vector i
//   pass         seq  -> host  truth_table matched expected
//   mismatch_idx seq  -> host  lowest failing vector index (0 on pass)
// Modports: master = host/gate side, slave = sequencer.
// ---------------------------------------------------------------------------
interface gate_tt_sequencer_if #(
    parameter int N_INPUTS = 2
);
    localparam int TT_W = 1 << N_INPUTS;

    logic                start;
    logic [TT_W-1:0]     expected;
    logic [N_INPUTS-1:0] gate_in;
    logic                gate_out;
    logic                busy;
    logic                done;
    logic [TT_W-1:0]     truth_table;
    logic                pass;
    logic [N_INPUTS-1:0] mismatch_idx;

    modport master (
        output start,
        output expected,
        output gate_out,
        input  gate_in,
        input  busy,
        input  done,
        input  truth_table,
        input  pass,
        input  mismatch_idx
    );

    modport slave (
        input  start,
        input  expected,
        input  gate_out,
        output gate_in,
        output busy,
        output done,
        output truth_table,
        output pass,
        output mismatch_idx
    );
endinterface

// File: rtl/gate_tt_sequencer.sv
// ---------------------------------------------------------------------------
// gate_tt_sequencer
// Purpose : exhaustively drives every input vector 0..2**N_INPUTS-1 onto a
//           combinational gate, samples the gate output after SETTLE_CYCLES
//           cycles per vector, builds the truth table and compares it with a
//           latched expected table.
// Ports   :
//   clk    in  single clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    gate_tt_sequencer_if.slave (start/expected/gate_out in;
//          gate_in/busy/done/truth_table/pass/mismatch_idx out)
// Parameters:
//   N_INPUTS      number of gate inputs (table is 2**N_INPUTS bits)
//   SETTLE_CYCLES cycles each vector is held before sampling (>= 1)
// Configuration macro:
//   GATE_TT_EARLY_ABORT_EN  when defined, the first failing vector ends the
//                           run immediately (done arrives early, unvisited
//                           table bits stay 0).
// All outputs are driven straight from registers.
// ---------------------------------------------------------------------------
module gate_tt_sequencer #(
    parameter int N_INPUTS      = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_tt_sequencer_if.slave    bus
);
    localparam int TT_W  = 1 << N_INPUTS;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] VEC_MAX     = {N_INPUTS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Index of the lowest set bit of v; 0 when v is all zeros.
    function automatic logic [N_INPUTS-1:0] lowest_set(input logic [TT_W-1:0] v);
        logic [N_INPUTS-1:0] idx;
        idx = {N_INPUTS{1'b0}};
        for (int i = TT_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = N_INPUTS'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t              r_state,   w_state_nxt;
    logic [N_INPUTS-1:0] r_gate_in, w_gate_in_nxt;
    logic [CNT_W-1:0]    r_cnt,     w_cnt_nxt;
    logic [TT_W-1:0]     r_truth,   w_truth_nxt;
    logic [TT_W-1:0]     r_exp,     w_exp_nxt;
    logic                r_pass,    w_pass_nxt;
    logic [N_INPUTS-1:0] r_mis,     w_mis_nxt;
    logic                r_busy,    w_busy_nxt;
    logic                r_done,    w_done_nxt;

    logic [TT_W-1:0]     w_tt_cap;   // table including the bit sampled this cycle
    logic [TT_W-1:0]     w_diff;     // captured vs latched expected
    logic                w_abort;    // current vector fails and early abort is built in

    // Next-state and next-output logic for the sequencer FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_gate_in_nxt = r_gate_in;
        w_cnt_nxt     = r_cnt;
        w_truth_nxt   = r_truth;
        w_exp_nxt     = r_exp;
        w_pass_nxt    = r_pass;
        w_mis_nxt     = r_mis;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        w_tt_cap            = r_truth;
        w_tt_cap[r_gate_in] = bus.gate_out;
        w_diff              = w_tt_cap ^ r_exp;
`ifdef GATE_TT_EARLY_ABORT_EN
        w_abort = (bus.gate_out != r_exp[r_gate_in]);
`else
        w_abort = 1'b0;
`endif

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_exp_nxt     = bus.expected;
                    w_gate_in_nxt = {N_INPUTS{1'b0}};
                    w_cnt_nxt     = {CNT_W{1'b0}};
                    w_truth_nxt   = {TT_W{1'b0}};
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = ST_SETTLE;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end

            ST_SAMPLE: begin
                w_truth_nxt = w_tt_cap;
                if (w_abort || (r_gate_in == VEC_MAX)) begin
                    // Earlier vectors all matched on an abort, so the lowest
                    // differing bit is the current vector in that case too.
                    w_state_nxt = ST_FINISH;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_diff == {TT_W{1'b0}});
                    w_mis_nxt   = lowest_set(w_diff);
                end else begin
                    w_gate_in_nxt = r_gate_in + N_INPUTS'(1);
                    w_cnt_nxt     = {CNT_W{1'b0}};
                    w_state_nxt   = ST_SETTLE;
                end
            end

            ST_FINISH: begin
                w_state_nxt   = ST_IDLE;
                w_busy_nxt    = 1'b0;
                w_gate_in_nxt = {N_INPUTS{1'b0}};
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_busy_nxt    = 1'b0;
                w_gate_in_nxt = {N_INPUTS{1'b0}};
                w_cnt_nxt     = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gate_in <= {N_INPUTS{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_truth   <= {TT_W{1'b0}};
            r_exp     <= {TT_W{1'b0}};
            r_pass    <= 1'b0;
            r_mis     <= {N_INPUTS{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gate_in <= w_gate_in_nxt;
            r_cnt     <= w_cnt_nxt;
            r_truth   <= w_truth_nxt;
            r_exp     <= w_exp_nxt;
            r_pass    <= w_pass_nxt;
            r_mis     <= w_mis_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.gate_in      = r_gate_in;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.truth_table  = r_truth;
    assign bus.pass         = r_pass;
    assign bus.mismatch_idx = r_mis;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gate_tt_sequencer
// Directed bench for gate_tt_sequencer with default parameters. The gate under
// test is selectable (AND / OR / XOR). Each run pushes its expected result
// (done cycle, table, pass, mismatch index) into a queue; a monitor pops and
// compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_gate_tt_sequencer;
    localparam int N  = 2;
    localparam int SC = 2;
    localparam int LAT = (1 << N) * (SC + 1);   // 12

    typedef struct {
        logic [3:0] tt;
        logic       pass;
        logic [1:0] mis;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [1:0] gate_kind;
    int   cyc;
    int   errors;
    int   checks;
    exp_t sb_q[$];
    exp_t mon_e;

    gate_tt_sequencer_if #(.N_INPUTS(N)) bus ();

    gate_tt_sequencer #(.N_INPUTS(N), .SETTLE_CYCLES(SC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Gate under test.
    assign bus.gate_out = (gate_kind == 2'd0) ? (&bus.gate_in) :
                          (gate_kind == 2'd1) ? (|bus.gate_in) : (^bus.gate_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("done_cycle",   cyc,              mon_e.cyc);
                chk("truth_table",  bus.truth_table,  mon_e.tt);
                chk("pass",         bus.pass,         mon_e.pass);
                chk("mismatch_idx", bus.mismatch_idx, mon_e.mis);
            end
        end
    end

    // Apply start for one edge from idle; returns the cycle number after E0.
    task automatic issue(input logic [3:0] exp, input logic [1:0] kind, output int e0);
        @(negedge clk);
        gate_kind    = kind;
        bus.expected = exp;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic push(input logic [3:0] tt, input logic pass, input logic [1:0] mis, input int c);
        exp_t e;
        e.tt = tt; e.pass = pass; e.mis = mis; e.cyc = c;
        sb_q.push_back(e);
    endtask

    initial begin
        int e0;
        int exp_gi;
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.expected = 4'b0000;
        gate_kind    = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_gate_in", bus.gate_in,      2'b00);
        chk("rst_busy",    bus.busy,         1'b0);
        chk("rst_done",    bus.done,         1'b0);
        chk("rst_tt",      bus.truth_table,  4'b0000);
        chk("rst_pass",    bus.pass,         1'b0);
        chk("rst_mis",     bus.mismatch_idx, 2'b00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: AND vs AND table; expected changed mid-run must be ignored.
        issue(4'b1000, 2'd0, e0);
        push(4'b1000, 1'b1, 2'd0, e0 + LAT);
        bus.expected = 4'b0110;
        chk("t1_busy_start", bus.busy, 1'b1);
        chk("t1_gate_in_0",  bus.gate_in, 2'd0);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            exp_gi = (k < 12) ? (k / 3) : ((k == 12) ? 3 : 0);
            chk("t1_gate_in", bus.gate_in, exp_gi);
        end
        chk("t1_busy_end", bus.busy, 1'b0);
        repeat (5) @(negedge clk);
        chk("t1_hold_tt",   bus.truth_table, 4'b1000);
        chk("t1_hold_pass", bus.pass,        1'b1);

        // Test 2: AND vs OR expectation; start also clears the held table.
        issue(4'b1110, 2'd0, e0);
        chk("t2_tt_cleared", bus.truth_table, 4'b0000);
`ifdef GATE_TT_EARLY_ABORT_EN
        push(4'b0000, 1'b0, 2'd1, e0 + 6);
`else
        push(4'b1000, 1'b0, 2'd1, e0 + LAT);
`endif
        repeat (16) @(negedge clk);

        // Test 3: start pulses at E3 and E8 are ignored.
        issue(4'b1000, 2'd0, e0);
        push(4'b1000, 1'b1, 2'd0, e0 + LAT);
        repeat (2) @(posedge clk);
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk) bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk) bus.start = 1'b0;
        repeat (8) @(negedge clk);
        chk("t3_no_rerun", bus.busy, 1'b0);
        repeat (4) @(negedge clk);

        // Faulty-gate case: OR gate checked against the AND table.
        issue(4'b1000, 2'd1, e0);
`ifdef GATE_TT_EARLY_ABORT_EN
        push(4'b0010, 1'b0, 2'd1, e0 + 6);
`else
        push(4'b1110, 1'b0, 2'd1, e0 + LAT);
`endif
        repeat (16) @(negedge clk);

        // XOR gate against its own table.
        issue(4'b0110, 2'd2, e0);
        push(4'b0110, 1'b1, 2'd0, e0 + LAT);
        repeat (16) @(negedge clk);

        // Start held high: second run starts on the first idle cycle.
        @(negedge clk);
        gate_kind    = 2'd0;
        bus.expected = 4'b1000;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        push(4'b1000, 1'b1, 2'd0, e0 + LAT);
        push(4'b1000, 1'b1, 2'd0, e0 + LAT + 2 + LAT);
        repeat (13) @(posedge clk);
        @(negedge clk);
        chk("hold_idle_gap", bus.busy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("hold_retrigger", bus.busy, 1'b1);
        bus.start = 1'b0;
        repeat (16) @(negedge clk);

        // Test 4: reset at E7 aborts the run with no done pulse.
        issue(4'b1000, 2'd0, e0);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_gate_in", bus.gate_in,      2'b00);
        chk("t4_busy",    bus.busy,         1'b0);
        chk("t4_done",    bus.done,         1'b0);
        chk("t4_tt",      bus.truth_table,  4'b0000);
        chk("t4_pass",    bus.pass,         1'b0);
        chk("t4_mis",     bus.mismatch_idx, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(4'b1000, 2'd0, e0);
        push(4'b1000, 1'b1, 2'd0, e0 + LAT);
        repeat (16) @(negedge clk);

        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
